// File: rtl/sim_ds2s_rx.sv
// Multi-lane differential receiver model: decode, synchronise, debounce, count illegal pair states.
// Latency: valid/err_pulse SYNC_STAGES edges after input; o after SYNC_STAGES+FILTER_LEN-1 edges.
// No backpressure: one sample per lane per clock, never stalls.
module sim_ds2s_rx #(
  parameter int LANES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             i,
  input  logic [LANES-1:0]             ib,
  input  logic                         clr_err,
  output logic [LANES-1:0]             o,
  output logic [LANES-1:0]             valid,
  output logic [LANES-1:0]             err_pulse,
  output logic [LANES*ERR_CNT_W-1:0]   err_count
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  logic [LANES-1:0]                  w_legal;
  logic [LANES-1:0]                  w_val;
  logic [LANES-1:0]                  w_s_legal;
  logic [LANES-1:0]                  w_s_val;
  logic [LANES-1:0]                  w_event;

  logic [SYNC_STAGES-1:0][LANES-1:0] r_sync_legal;
  logic [SYNC_STAGES-1:0][LANES-1:0] r_sync_val;
  logic [LANES-1:0][CNT_W-1:0]       r_cnt;
  logic [LANES-1:0]                  r_o;
  logic [LANES-1:0]                  r_valid;
  logic [LANES-1:0]                  r_prev_legal;
  logic [LANES-1:0]                  r_err_pulse;
  logic [LANES-1:0][ERR_CNT_W-1:0]   r_err_cnt;

  // Decode each pair; case-equality makes X/Z on either leg count as illegal.
  always_comb begin
    w_legal = '0;
    w_val   = '0;
    for (int n = 0; n < LANES; n++) begin
      w_legal[n] = ((i[n] === 1'b1) && (ib[n] === 1'b0)) ||
                   ((i[n] === 1'b0) && (ib[n] === 1'b1));
      w_val[n]   = w_legal[n] & i[n];
    end
  end

  // Synchroniser shift register; resets to "legal, 0" so no error fires out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_legal <= '1;
      r_sync_val   <= '0;
    end else begin
      r_sync_legal[0] <= w_legal;
      r_sync_val[0]   <= w_val;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync_legal[s] <= r_sync_legal[s-1];
        r_sync_val[s]   <= r_sync_val[s-1];
      end
    end
  end

  assign w_s_legal = r_sync_legal[SYNC_STAGES-1];
  assign w_s_val   = r_sync_val[SYNC_STAGES-1];
  assign w_event   = r_prev_legal & ~w_s_legal;

  // Debounce: o follows only after FILTER_LEN consecutive legal samples differing from o.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_o   <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (!w_s_legal[n]) begin
          r_cnt[n] <= '0;
        end else if (w_s_val[n] == r_o[n]) begin
          r_cnt[n] <= '0;
        end else if (r_cnt[n] == CNT_LAST) begin
          r_o[n]   <= w_s_val[n];
          r_cnt[n] <= '0;
        end else begin
          r_cnt[n] <= r_cnt[n] + CNT_ONE;
        end
      end
    end
  end

  // Legality tracking and one-shot pulse on each legal->illegal transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_prev_legal <= '1;
      r_err_pulse  <= '0;
    end else begin
      r_valid      <= w_s_legal;
      r_prev_legal <= w_s_legal;
      r_err_pulse  <= w_event;
    end
  end

  // Saturating per-lane event counters; clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (clr_err) begin
          r_err_cnt[n] <= '0;
        end else if (w_event[n] && (r_err_cnt[n] != ERR_MAX)) begin
          r_err_cnt[n] <= r_err_cnt[n] + ERR_ONE;
        end
      end
    end
  end

  assign o         = r_o;
  assign valid     = r_valid;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_sim_ds2s_rx.sv
// Scoreboard bench for sim_ds2s_rx: default, FILTER_LEN=1 and ERR_CNT_W=2 instances share stimulus.
// Expected values are queued per edge when stimulus is applied; a negedge monitor pops and compares.
module tb_sim_ds2s_rx;

  localparam int S_O       = 0;
  localparam int S_VALID   = 1;
  localparam int S_PULSE   = 2;
  localparam int S_CNT     = 3;
  localparam int S_CNT_ALL = 4;
  localparam int S_O_F1    = 5;
  localparam int S_PULSE_E2 = 6;
  localparam int S_CNT_E2  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic [3:0]  i;
  logic [3:0]  ib;

  logic [3:0]  o, valid, err_pulse;
  logic [31:0] err_count;
  logic [3:0]  o_f1, valid_f1, pulse_f1;
  logic [31:0] cnt_f1;
  logic [3:0]  o_e2, valid_e2, pulse_e2;
  logic [7:0]  cnt_e2;

  typedef struct {
    int          cyc;
    int          sel;
    int          lane;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   ecnt   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sim_ds2s_rx dut (
    .clk(clk), .rst(rst), .i(i), .ib(ib), .clr_err(clr_err),
    .o(o), .valid(valid), .err_pulse(err_pulse), .err_count(err_count)
  );

  sim_ds2s_rx #(.FILTER_LEN(1)) dut_f1 (
    .clk(clk), .rst(rst), .i(i), .ib(ib), .clr_err(clr_err),
    .o(o_f1), .valid(valid_f1), .err_pulse(pulse_f1), .err_count(cnt_f1)
  );

  sim_ds2s_rx #(.ERR_CNT_W(2)) dut_e2 (
    .clk(clk), .rst(rst), .i(i), .ib(ib), .clr_err(clr_err),
    .o(o_e2), .valid(valid_e2), .err_pulse(pulse_e2), .err_count(cnt_e2)
  );

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [31:0] get_val(input int sel, input int lane);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_O:        v = (lane < 0) ? {28'b0, o} : {31'b0, o[lane]};
      S_VALID:    v = {28'b0, valid};
      S_PULSE:    v = {28'b0, err_pulse};
      S_CNT:      v = {24'b0, err_count[lane*8 +: 8]};
      S_CNT_ALL:  v = err_count;
      S_O_F1:     v = (lane < 0) ? {28'b0, o_f1} : {31'b0, o_f1[lane]};
      S_PULSE_E2: v = {31'b0, pulse_e2[lane]};
      S_CNT_E2:   v = {30'b0, cnt_e2[lane*2 +: 2]};
      default:    v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  // Queue an expectation for the state after relative edge rel (edge 0 = next rising edge).
  task automatic chk(input int rel, input int sel, input int lane,
                     input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = ecnt + 1 + rel;
    c.sel  = sel;
    c.lane = lane;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int n, input logic pi, input logic pib);
    i[n]  = pi;
    ib[n] = pib;
  endtask

  // Monitor: compare every queued expectation that falls due on this edge.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc <= ecnt) begin
        act = get_val(sb[k].sel, sb[k].lane);
        n_chk++;
        if (sb[k].cyc < ecnt) begin
          n_fail++;
          $display("FAIL %s: check for edge %0d missed (now %0d), required %0h",
                   sb[k].name, sb[k].cyc, ecnt, sb[k].exp);
        end else if (act !== sb[k].exp) begin
          n_fail++;
          $display("FAIL %s at edge %0d lane %0d: got %0h, required %0h",
                   sb[k].name, ecnt, sb[k].lane, act, sb[k].exp);
        end
        sb.delete(k);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    clr_err = 1'b0;
    i       = 4'b0000;
    ib      = 4'b1111;

    // Reset state after three reset edges.
    chk(2, S_O,       -1, 0, "rst_o");
    chk(2, S_VALID,   -1, 0, "rst_valid");
    chk(2, S_PULSE,   -1, 0, "rst_pulse");
    chk(2, S_CNT_ALL, -1, 0, "rst_cnt");
    repeat (3) step();

    // Idle for 10 cycles after release.
    rst = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk(r, S_PULSE, -1, 0, "idle_pulse");
      chk(r, S_O,     -1, 0, "idle_o");
      if (r >= 2) chk(r, S_VALID, -1, 32'hF, "idle_valid");
    end
    chk(9, S_CNT_ALL, -1, 0, "idle_cnt");
    repeat (10) step();

    // Lane 0 rises: edge 4 with defaults, edge 2 with FILTER_LEN=1; then falls back.
    set_lane(0, 1'b1, 1'b0);
    chk(3, S_O,    0,  0,       "l0_rise_early");
    chk(4, S_O,    0,  1,       "l0_rise");
    chk(4, S_O,    -1, 32'h1,   "l0_others");
    chk(1, S_O_F1, 0,  0,       "f1_rise_early");
    chk(2, S_O_F1, 0,  1,       "f1_rise");
    repeat (6) step();
    set_lane(0, 1'b0, 1'b1);
    chk(3, S_O, 0, 1, "l0_fall_early");
    chk(4, S_O, 0, 0, "l0_fall");
    repeat (6) step();

    // Lane 1: two legal samples, one (1,1), then legal held -> restart, rise at edge 7.
    set_lane(1, 1'b1, 1'b0);
    chk(4, S_O,     1,  0,       "l1_restart4");
    chk(6, S_O,     1,  0,       "l1_restart6");
    chk(7, S_O,     1,  1,       "l1_rise");
    chk(4, S_PULSE, -1, 32'h2,   "l1_pulse");
    chk(4, S_VALID, -1, 32'hD,   "l1_valid");
    chk(5, S_PULSE, -1, 0,       "l1_pulse_once");
    chk(5, S_CNT,   1,  1,       "l1_cnt");
    repeat (2) step();
    set_lane(1, 1'b1, 1'b1);
    step();
    set_lane(1, 1'b1, 1'b0);
    repeat (8) step();

    // Lane 2: unknown legs for 4 cycles -> one pulse, valid low 4 cycles, o holds.
    set_lane(2, 1'bx, 1'bx);
    chk(1, S_VALID, -1, 32'hF, "l2_valid_pre");
    chk(2, S_PULSE, -1, 32'h4, "l2_pulse");
    chk(3, S_PULSE, -1, 0,     "l2_pulse_once");
    for (int r = 2; r <= 5; r++) chk(r, S_VALID, -1, 32'hB, "l2_valid_low");
    chk(6, S_VALID, -1, 32'hF, "l2_valid_back");
    chk(6, S_CNT,   2,  1,     "l2_cnt");
    chk(6, S_O,     -1, 32'h2, "l2_o_hold");
    repeat (4) step();
    set_lane(2, 1'b0, 1'b1);
    repeat (4) step();

    // Lane 3: five illegal bursts; 2-bit counter saturates at 3.
    for (int b = 0; b < 5; b++) begin
      set_lane(3, 1'b1, 1'b1);
      chk(2, S_PULSE_E2, 3, 1, "e2_pulse");
      chk(2, S_CNT_E2,   3, (b < 2) ? b + 1 : 3, "e2_sat");
      if (b == 0) chk(3, S_PULSE_E2, 3, 0, "e2_pulse_once");
      if (b == 4) chk(2, S_CNT, 3, 5, "l3_cnt_wide");
      step();
      set_lane(3, 1'b0, 1'b1);
      repeat (2) step();
    end

    // Sixth event with clr_err on the same edge: pulse fires, count cleared.
    set_lane(3, 1'b1, 1'b1);
    chk(2, S_PULSE_E2, 3,  1, "clr_pulse");
    chk(2, S_CNT_E2,   3,  0, "clr_cnt");
    chk(2, S_CNT_ALL,  -1, 0, "clr_all");
    step();
    set_lane(3, 1'b0, 1'b1);
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    repeat (3) step();

    // Reset while lane 0 is mid-filter (cnt=1 after edge 2).
    set_lane(0, 1'b1, 1'b0);
    chk(2, S_O, 0, 0, "mid_filter");
    repeat (3) step();
    rst = 1'b1;
    chk(0, S_O,       -1, 0, "midrst_o");
    chk(0, S_VALID,   -1, 0, "midrst_valid");
    chk(0, S_PULSE,   -1, 0, "midrst_pulse");
    chk(0, S_CNT_ALL, -1, 0, "midrst_cnt");
    step();
    rst = 1'b0;
    chk(3, S_O,    -1, 0,     "refill_early");
    chk(4, S_O,    -1, 32'h3, "refill");
    chk(1, S_O_F1, -1, 0,     "f1_refill_early");
    chk(2, S_O_F1, -1, 32'h3, "f1_refill");
    for (int r = 0; r < 5; r++) chk(r, S_PULSE, -1, 0, "refill_no_pulse");
    repeat (8) step();

    // Anything still queued was never compared.
    while (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: never compared, due at edge %0d, required %0h",
               sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_ds2s_rx.md
# sim_ds2s_rx

Parametrised simulation model of a multi-lane differential input receiver. It is the successor to the single-pair combinational differential-to-single-ended model. Per lane it:
- decodes the pair and flags illegal pair states, including X/Z;
- synchronises the result into one clock domain;
- debounces the output;
- counts illegal-state events.

It sits between testbench-driven differential pins and core logic in simulation builds, replacing a vendor input buffer plus synchroniser.

## Interface
Parameters:
- LANES, 4, number of differential pairs (>=1)
- SYNC_STAGES, 2, synchroniser depth (>=1)
- FILTER_LEN, 3, consecutive legal, differing samples required before `o` changes (>=1; 1 disables filtering)
- ERR_CNT_W, 8, width of each per-lane saturating error counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i  in  LANES  positive leg per lane
- ib  in  LANES  negative leg per lane
- clr_err  in  1  synchronous clear of all error counters
- o  out  LANES  filtered single-ended value per lane
- valid  out  LANES  registered legality of synchronised sample per lane
- err_pulse  out  LANES  one-cycle pulse on legal->illegal transition per lane
- err_count  out  LANES*ERR_CNT_W  saturating event counters; lane n at bits [n*ERR_CNT_W +: ERR_CNT_W]

## Operation
- Decode, per lane, combinational:
  - legal = (i,ib) is exactly (1,0) or (0,1), evaluated with case-equality.
  - (0,0), (1,1) and any X/Z on either leg are illegal.
  - Decoded value = i when legal, 0 otherwise.
- Synchroniser: SYNC_STAGES-deep shift register of {legal, value} per lane; last stage is {s_legal, s_val}.
- Filter: per-lane counter cnt, width clog2(FILTER_LEN)+1. Each edge:
  - if !s_legal: cnt<=0; o holds.
  - else if s_val==o: cnt<=0.
  - else if cnt==FILTER_LEN-1: o<=s_val, cnt<=0.
  - else: cnt<=cnt+1.
- An illegal sample mid-count restarts the count. A return to the current o value mid-count also restarts it.
- Legality tracking: valid<=s_legal; prev_legal<=s_legal.
- Error event: err_pulse<=prev_legal & !s_legal. Continuous illegality produces one event only.
- Counter, per lane:
  - clr_err has priority: count<=0, even if an event occurs the same cycle.
  - Otherwise an event increments the count, saturating at 2^ERR_CNT_W-1.
  - err_pulse still fires when clr_err is high.
- Lanes are fully independent; no shared state except clr_err.

## Timing
- Reset values:
  - o=0, valid=0, err_pulse=0, err_count=0, cnt=0.
  - Synchroniser stages={legal=1,value=0}; prev_legal=1.
  - No spurious err_pulse out of reset.
- Reset mid-operation discards filter progress and pipeline contents; outputs return to reset values on the edge after rst sampled high.
- Reset has priority over clr_err.
- Reference point: input applied before edge 0.
  - Last sync stage reflects it after edge SYNC_STAGES-1.
  - valid and err_pulse reflect it after edge SYNC_STAGES; defaults: 3rd edge.
  - o changes after edge SYNC_STAGES+FILTER_LEN-1, provided input is held legal and constant; defaults: 5th edge.
  - err_count updates on the same edge as err_pulse.
- Throughput: one sample per lane per clock; no stalls.

## Test plan
- Reset then idle (i=0, ib=1 all lanes) for 10 cycles -> o=0, valid=1 from 3rd cycle after reset release, err_pulse never asserted, err_count=0.
- Lane 0 switched to (1,0) and held, defaults -> o[0] rises after 5th edge; other lanes unchanged. Repeat with FILTER_LEN=1 -> rises after 3rd edge.
- Lane 1 driven (1,0) for 2 cycles, then (1,1) for 1 cycle, then (1,0) held -> count restarts on the illegal sample; o[1] rises 3 edges after the last stage is legal again.
- Lane 2 driven X on ib for 4 cycles -> single err_pulse[2] after 3rd edge, valid[2]=0 for 4 cycles, err_count lane 2=1, o[2] holds.
- ERR_CNT_W=2: 5 separate illegal bursts on lane 3 -> count 1,2,3,3,3 (saturates). Then clr_err asserted on the same cycle as a 6th event -> err_pulse[3]=1 and count=0.
- rst asserted while lane 0 is mid-filter (cnt=1) -> after the edge, all outputs are at reset values. A re-applied new value takes the full 5 edges.
